deserializer: RTL and testbench



---
 rtl/deserializer.sv | 141 ++++++++++++++
 tb/tb_deserializer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/deserializer.sv
// deserializer: collects an MSB-first byte stream into 32-bit words.
// A start-of-word marker (Sof) frames each word. Bytes that arrive without
// a preceding Sof, and a Sof that interrupts a partial word, are reported
// as framing errors. Completed words are held in a small output FIFO that
// the consumer drains with a valid/ready handshake.
// Optional feature: define DESER_ERRCNT_EN to add the saturating ErrCnt
// framing-error counter port.
module deserializer #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  Din,
    input  logic        Vin,
    input  logic        Sof,
    output logic [31:0] Dout,
    output logic        Dv,
    input  logic        Dready,
    output logic        Done,
    output logic        Err,
    output logic        Ovf
`ifdef DESER_ERRCNT_EN
    ,
    output logic [7:0]  ErrCnt
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t      state;
    logic [1:0]  idx;       // next byte slot to fill
    logic [23:0] partial;   // bytes 0..2; byte 3 goes straight into the FIFO

    logic [31:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    logic empty;
    logic full;
    logic pop;
    logic push_req;
    logic push_ok;
    logic err_evt;

    // The extra pointer MSB separates "full" from "empty" when the low bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign Dv    = !empty;
    assign pop   = Dv && Dready;
    assign Dout  = empty ? 32'd0 : mem[rd_ptr[AW-1:0]];

    // Byte 3 arriving in COLLECT completes a word. A full FIFO still accepts
    // the word if the head leaves at the same edge.
    assign push_req = (state == COLLECT) && Vin && !Sof && (idx == 2'd3);
    assign push_ok  = push_req && (!full || pop);

    // Framing error: data byte while idle, or Sof that interrupts a partial word.
    assign err_evt  = Vin && ((state == IDLE) ? !Sof : Sof);

    // Framing FSM: byte collection plus the registered status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= 2'd0;
            partial <= 24'd0;
            Done    <= 1'b0;
            Err     <= 1'b0;
            Ovf     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every register here see the
            // pre-edge values of the others, so statement order does not matter.
            Done <= push_ok;
            Ovf  <= push_req && !push_ok;
            Err  <= err_evt;
            if (Vin) begin
                if (Sof) begin
                    // A Sof always restarts a word, even over a partial one.
                    partial[23:16] <= Din;
                    idx            <= 2'd1;
                    state          <= COLLECT;
                end else if (state == COLLECT) begin
                    case (idx)
                        2'd1: begin
                            partial[15:8] <= Din;
                            idx           <= 2'd2;
                        end
                        2'd2: begin
                            partial[7:0] <= Din;
                            idx          <= 2'd3;
                        end
                        default: begin
                            idx   <= 2'd0;
                            state <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

    // FIFO storage: written only when a completed word is accepted.
    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are valid, and Dout is forced to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= {partial, Din};
        end
    end

    // FIFO pointers: advance on accepted push and on consumer pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

`ifdef DESER_ERRCNT_EN
    // Saturating count of framing errors; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ErrCnt <= 8'd0;
        end else if (err_evt && (ErrCnt != 8'hFF)) begin
            ErrCnt <= ErrCnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_deserializer.sv
// tb_deserializer: table-driven vectors, hand-written multi-cycle sequences
// and randomized traffic, all compared against a byte/word queue model.
module tb_deserializer;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst;
    logic [7:0]  Din;
    logic        Vin;
    logic        Sof;
    logic [31:0] Dout;
    logic        Dv;
    logic        Dready;
    logic        Done;
    logic        Err;
    logic        Ovf;
`ifdef DESER_ERRCNT_EN
    logic [7:0]  ErrCnt;
`endif

    deserializer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .Din    (Din),
        .Vin    (Vin),
        .Sof    (Sof),
        .Dout   (Dout),
        .Dv     (Dv),
        .Dready (Dready),
        .Done   (Done),
        .Err    (Err),
        .Ovf    (Ovf)
`ifdef DESER_ERRCNT_EN
        ,
        .ErrCnt (ErrCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n_done = 0;
    int n_ovf  = 0;

    // Reference model: bytes of the word being framed, and the output queue.
    logic [7:0]  mb[$];
    logic [31:0] mq[$];
    bit          in_word = 0;
    int          err_cnt = 0;

    typedef struct {
        logic        vin;
        logic        sof;
        logic [7:0]  din;
        logic        rdy;
        logic        done;
        logic        err;
        logic        ovf;
        logic        dv;
        logic [31:0] dout;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mb.delete();
        mq.delete();
        in_word = 0;
        err_cnt = 0;
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic cycle(input logic vin, input logic sof, input logic [7:0] din, input logic rdy);
        bit          pop    = 0;
        bit          push   = 0;
        bit          e_done = 0;
        bit          e_err  = 0;
        bit          e_ovf  = 0;
        logic [31:0] w      = 32'd0;
        Vin    = vin;
        Sof    = sof;
        Din    = din;
        Dready = rdy;
        pop = (mq.size() > 0) && rdy;
        if (vin) begin
            if (sof) begin
                if (in_word) e_err = 1;
                mb.delete();
                mb.push_back(din);
                in_word = 1;
            end else if (!in_word) begin
                e_err = 1;
            end else begin
                mb.push_back(din);
                if (mb.size() == 4) begin
                    w = {mb[0], mb[1], mb[2], mb[3]};
                    mb.delete();
                    in_word = 0;
                    push = 1;
                end
            end
        end
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(w);
                e_done = 1;
            end else begin
                e_ovf = 1;
            end
        end
        if (e_err && err_cnt < 255) err_cnt++;
        @(posedge clk);
        #1;
        check("done", 32'(Done), 32'(e_done));
        check("err",  32'(Err),  32'(e_err));
        check("ovf",  32'(Ovf),  32'(e_ovf));
        check("dv",   32'(Dv),   32'(mq.size() > 0));
        if (mq.size() > 0) check("dout", Dout, mq[0]);
`ifdef DESER_ERRCNT_EN
        check("errcnt", 32'(ErrCnt), 32'(err_cnt));
`endif
        n_done += int'(Done);
        n_ovf  += int'(Ovf);
    endtask

    task automatic send_word(input logic [31:0] w, input logic rdy);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, i == 0, w[31 - 8*i -: 8], rdy);
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        Vin    = 1'b0;
        Sof    = 1'b0;
        Din    = 8'd0;
        Dready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        check("rst_dout", Dout, 32'd0);
        check("rst_dv",   32'(Dv),   32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_err",  32'(Err),  32'd0);
        check("rst_ovf",  32'(Ovf),  32'd0);
`ifdef DESER_ERRCNT_EN
        check("rst_errcnt", 32'(ErrCnt), 32'd0);
`endif
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] gb[4];

        do_reset();

        // Single word, framing error, stray byte.
        tbl.push_back('{1, 1, 8'hDE, 1, 0, 0, 0, 0, 32'h0});
        tbl.push_back('{1, 0, 8'hAD, 1, 0, 0, 0, 0, 32'h0});
        tbl.push_back('{1, 0, 8'hBE, 1, 0, 0, 0, 0, 32'h0});
        tbl.push_back('{1, 0, 8'hEF, 1, 1, 0, 0, 1, 32'hDEADBEEF});
        tbl.push_back('{0, 0, 8'h00, 1, 0, 0, 0, 0, 32'h0});
        tbl.push_back('{1, 1, 8'h11, 1, 0, 0, 0, 0, 32'h0});
        tbl.push_back('{1, 0, 8'h22, 1, 0, 0, 0, 0, 32'h0});
        tbl.push_back('{1, 1, 8'hAA, 1, 0, 1, 0, 0, 32'h0});
        tbl.push_back('{1, 0, 8'hBB, 1, 0, 0, 0, 0, 32'h0});
        tbl.push_back('{1, 0, 8'hCC, 1, 0, 0, 0, 0, 32'h0});
        tbl.push_back('{1, 0, 8'hDD, 1, 1, 0, 0, 1, 32'hAABBCCDD});
        tbl.push_back('{0, 0, 8'h00, 1, 0, 0, 0, 0, 32'h0});
        tbl.push_back('{1, 0, 8'h55, 1, 0, 1, 0, 0, 32'h0});
        tbl.push_back('{0, 0, 8'h00, 1, 0, 0, 0, 0, 32'h0});

        foreach (tbl[i]) begin
            cycle(tbl[i].vin, tbl[i].sof, tbl[i].din, tbl[i].rdy);
            check("tbl_done", 32'(Done), 32'(tbl[i].done));
            check("tbl_err",  32'(Err),  32'(tbl[i].err));
            check("tbl_ovf",  32'(Ovf),  32'(tbl[i].ovf));
            check("tbl_dv",   32'(Dv),   32'(tbl[i].dv));
            if (tbl[i].dv) check("tbl_dout", Dout, tbl[i].dout);
        end
`ifdef DESER_ERRCNT_EN
        check("errcnt_after_tbl", 32'(ErrCnt), 32'd2);
`endif

        // Gapped word: two idle cycles after every byte.
        gb = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, i == 0, gb[i], 1'b1);
            if (i == 3) begin
                check("gap_done", 32'(Done), 32'd1);
                check("gap_dout", Dout, 32'hDEADBEEF);
            end
            repeat (2) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        end

        // Backpressure and overflow: three words into a two-entry FIFO.
        n_done = 0;
        n_ovf  = 0;
        send_word(32'h01020304, 1'b0);
        send_word(32'h05060708, 1'b0);
        send_word(32'h090A0B0C, 1'b0);
        check("ovf_done_count", 32'(n_done), 32'd2);
        check("ovf_ovf_count",  32'(n_ovf),  32'd1);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        check("ovf_head1", Dout, 32'h01020304);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("ovf_head2", Dout, 32'h05060708);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("ovf_drained", 32'(Dv), 32'd0);

        // Full FIFO with a pop in the same cycle as the final byte.
        send_word(32'hA1A2A3A4, 1'b0);
        send_word(32'hB1B2B3B4, 1'b0);
        cycle(1'b1, 1'b1, 8'hC1, 1'b0);
        cycle(1'b1, 1'b0, 8'hC2, 1'b0);
        cycle(1'b1, 1'b0, 8'hC3, 1'b0);
        cycle(1'b1, 1'b0, 8'hC4, 1'b1);
        check("fullpop_ovf",  32'(Ovf),  32'd0);
        check("fullpop_done", 32'(Done), 32'd1);
        check("fullpop_head", Dout, 32'hB1B2B3B4);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("fullpop_new", Dout, 32'hC1C2C3C4);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("fullpop_empty", 32'(Dv), 32'd0);

        // Reset mid-word with a word buffered: both are lost.
        send_word(32'h12345678, 1'b0);
        cycle(1'b1, 1'b1, 8'h9A, 1'b0);
        cycle(1'b1, 1'b0, 8'hBC, 1'b0);
        do_reset();
        cycle(1'b1, 1'b0, 8'h77, 1'b1);
        check("post_rst_err", 32'(Err), 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            cycle(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 5) == 0),
                  8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
